// File: rtl/clock_divider.sv
// Multi-channel programmable tick / divided-clock generator.
// Define CLOCK_CYCLE_CNT_EN to add the per-channel o_cycles rising-edge counter.
module clock_divider #(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned DEF_DIV = 9,
  parameter logic        RST_LVL = 1'b0
`ifdef CLOCK_CYCLE_CNT_EN
  ,
  parameter int unsigned CNT_W   = 8
`endif
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [N_CH-1:0]         i_en,
  input  logic                    i_sync,
  input  logic [N_CH*DIV_W-1:0]   i_div,
  output logic [N_CH-1:0]         o_tick,
  output logic [N_CH-1:0]         o_clk
`ifdef CLOCK_CYCLE_CNT_EN
  ,
  output logic [N_CH*CNT_W-1:0]   o_cycles
`endif
);

  localparam int unsigned DW = DIV_W;

  logic [DW-1:0]   cnt_q [N_CH];
  logic [DW-1:0]   cnt_d [N_CH];
  logic [DW-1:0]   div_q [N_CH];
  logic [DW-1:0]   div_d [N_CH];
  logic [N_CH-1:0] clk_q, clk_d;
  logic [N_CH-1:0] tick_q, tick_d;

`ifdef CLOCK_CYCLE_CNT_EN
  logic [CNT_W-1:0] cyc_q [N_CH];
  logic [CNT_W-1:0] cyc_d [N_CH];
`endif

  // Per-channel next state: sync beats enable; div is only resampled at rollover.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      cnt_d[c]  = cnt_q[c];
      div_d[c]  = div_q[c];
      clk_d[c]  = clk_q[c];
      tick_d[c] = 1'b0;
`ifdef CLOCK_CYCLE_CNT_EN
      cyc_d[c]  = cyc_q[c];
`endif
      if (i_sync) begin
        cnt_d[c] = '0;
        div_d[c] = i_div[c*DW +: DW];
        clk_d[c] = RST_LVL;
`ifdef CLOCK_CYCLE_CNT_EN
        cyc_d[c] = '0;
`endif
      end else if (i_en[c]) begin
        if (cnt_q[c] == div_q[c]) begin
          cnt_d[c]  = '0;
          div_d[c]  = i_div[c*DW +: DW];
          clk_d[c]  = ~clk_q[c];
          tick_d[c] = 1'b1;
`ifdef CLOCK_CYCLE_CNT_EN
          if (!clk_q[c]) begin
            cyc_d[c] = cyc_q[c] + CNT_W'(1);
          end
`endif
        end else begin
          cnt_d[c] = cnt_q[c] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int c = 0; c < N_CH; c++) begin
        cnt_q[c] <= '0;
        div_q[c] <= DW'(DEF_DIV);
`ifdef CLOCK_CYCLE_CNT_EN
        cyc_q[c] <= '0;
`endif
      end
      clk_q  <= {N_CH{RST_LVL}};
      tick_q <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        cnt_q[c] <= cnt_d[c];
        div_q[c] <= div_d[c];
`ifdef CLOCK_CYCLE_CNT_EN
        cyc_q[c] <= cyc_d[c];
`endif
      end
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign o_tick = tick_q;
  assign o_clk  = clk_q;

`ifdef CLOCK_CYCLE_CNT_EN
  always_comb begin
    o_cycles = '0;
    for (int c = 0; c < N_CH; c++) begin
      o_cycles[c*CNT_W +: CNT_W] = cyc_q[c];
    end
  end
`endif

endmodule

// File: tb/tb_clock_divider.sv
// Self-checking bench for clock_divider: absolute-deadline reference model plus directed scenarios.
module tb_clock_divider;

  localparam int unsigned N_CH    = 2;
  localparam int unsigned DIV_W   = 16;
  localparam int unsigned DEF_DIV = 9;
`ifdef CLOCK_CYCLE_CNT_EN
  localparam int unsigned CNT_W   = 2;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  sync = 1'b0;
  logic [N_CH-1:0]       en = '1;
  logic [N_CH*DIV_W-1:0] div = {16'd9, 16'd9};
  logic [N_CH-1:0]       tick;
  logic [N_CH-1:0]       oclk;
`ifdef CLOCK_CYCLE_CNT_EN
  logic [N_CH*CNT_W-1:0] cycles;
`endif

  clock_divider #(
    .N_CH(N_CH), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV), .RST_LVL(1'b0)
`ifdef CLOCK_CYCLE_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_sync(sync), .i_div(div),
    .o_tick(tick), .o_clk(oclk)
`ifdef CLOCK_CYCLE_CNT_EN
    , .o_cycles(cycles)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model: each channel ticks at an absolute cycle number (deadline); a frozen cycle pushes it out.
  int   m_dl   [N_CH];
  logic m_clk  [N_CH];
  logic m_tick [N_CH];
  int   m_cyc  [N_CH];
  int   tq0[$];
  int   tq1[$];
  int   rq0[$];
  int   cq0[$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always begin
    @(posedge clk);
    cyc++;
    for (int c = 0; c < N_CH; c++) begin
      if (rst) begin
        m_clk[c] = 1'b0; m_tick[c] = 1'b0; m_cyc[c] = 0;
        m_dl[c]  = cyc + int'(DEF_DIV) + 1;
      end else if (sync) begin
        m_clk[c] = 1'b0; m_tick[c] = 1'b0; m_cyc[c] = 0;
        m_dl[c]  = cyc + int'(div[c*DIV_W +: DIV_W]) + 1;
      end else if (!en[c]) begin
        m_tick[c] = 1'b0;
        m_dl[c]++;
      end else if (cyc == m_dl[c]) begin
        m_tick[c] = 1'b1;
        m_clk[c]  = !m_clk[c];
        m_dl[c]   = cyc + int'(div[c*DIV_W +: DIV_W]) + 1;
        if (m_clk[c]) m_cyc[c] = (m_cyc[c] + 1) % 4;
        if (c == 0) begin
          tq0.push_back(cyc);
          if (m_clk[c]) begin
            rq0.push_back(cyc);
            cq0.push_back(m_cyc[c]);
          end
        end else begin
          tq1.push_back(cyc);
        end
      end else begin
        m_tick[c] = 1'b0;
      end
    end
    #1;
    for (int c = 0; c < N_CH; c++) begin
      chk($sformatf("tick[%0d]", c), int'(tick[c]), int'(m_tick[c]));
      chk($sformatf("clk[%0d]", c), int'(oclk[c]), int'(m_clk[c]));
`ifdef CLOCK_CYCLE_CNT_EN
      chk($sformatf("cycles[%0d]", c), int'(cycles[c*CNT_W +: CNT_W]), m_cyc[c]);
`endif
    end
  end

  int rel;

  task automatic do_reset(input logic [15:0] d0, input logic [15:0] d1);
    @(negedge clk);
    rst = 1'b1; sync = 1'b0; en = '1; div = {d1, d0};
    repeat (4) @(negedge clk);
    chk("reset_clk", int'(oclk), 0);
    chk("reset_tick", int'(tick), 0);
    rst = 1'b0;
    rel = cyc;
    tq0.delete(); tq1.delete(); rq0.delete(); cq0.delete();
  endtask

  task automatic wait_q(input int ch, input int n, input int budget, input string name);
    int b;
    b = budget;
    while (((ch == 0) ? tq0.size() : tq1.size()) < n && b > 0) begin
      @(negedge clk);
      b--;
    end
    if (b == 0) chk({name, "_timeout"}, (ch == 0) ? tq0.size() : tq1.size(), n);
  endtask

  int s_cyc;

  initial begin
    // reset timing and default period
    do_reset(16'd9, 16'd9);
    wait_q(0, 3, 80, "rst");
    if (tq0.size() >= 3 && rq0.size() >= 2) begin
      chk("first_tick_lat", tq0[0] - rel, 10);
      chk("half_period", tq0[1] - tq0[0], 10);
      chk("full_period", rq0[1] - rq0[0], 20);
    end

    // div 0 and div 3 channels
    do_reset(16'd0, 16'd3);
    wait_q(1, 4, 80, "div03");
    if (tq0.size() >= 3 && tq1.size() >= 3) begin
      chk("ch0_first", tq0[0] - rel, 10);
      chk("ch0_div0_a", tq0[1] - tq0[0], 1);
      chk("ch0_div0_b", tq0[2] - tq0[1], 1);
      chk("ch1_div3_a", tq1[1] - tq1[0], 4);
      chk("ch1_div3_b", tq1[2] - tq1[1], 4);
    end

    // divide change mid half-period
    do_reset(16'd9, 16'd9);
    wait_q(0, 1, 40, "chg1");
    repeat (3) @(negedge clk);
    div[15:0] = 16'd4;
    wait_q(0, 3, 60, "chg2");
    if (tq0.size() >= 3) begin
      chk("chg_old_half", tq0[1] - tq0[0], 10);
      chk("chg_new_half", tq0[2] - tq0[1], 5);
    end

    // enable freeze at cnt=3 for 7 cycles
    do_reset(16'd9, 16'd9);
    wait_q(0, 1, 40, "en1");
    repeat (3) @(negedge clk);
    en = '0;
    repeat (4) @(negedge clk);
    chk("frozen_clk", int'(oclk[0]), 1);
    chk("frozen_tick", int'(tick), 0);
    repeat (3) @(negedge clk);
    en = '1;
    wait_q(0, 2, 40, "en2");
    if (tq0.size() >= 2) chk("resume_gap", tq0[1] - tq0[0], 17);

    // sync pulse while o_clk high
    do_reset(16'd9, 16'd9);
    wait_q(0, 1, 40, "sync1");
    repeat (2) @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    s_cyc = cyc;
    chk("sync_clk", int'(oclk), 0);
    chk("sync_tick", int'(tick), 0);
    wait_q(1, 2, 40, "sync2");
    if (tq0.size() >= 2 && tq1.size() >= 2) begin
      chk("sync_realign0", tq0[1] - s_cyc, 10);
      chk("sync_realign1", tq1[1] - s_cyc, 10);
    end

`ifdef CLOCK_CYCLE_CNT_EN
    // 2-bit rising edge counter wraps
    do_reset(16'd0, 16'd0);
    wait_q(0, 12, 60, "cyc");
    if (cq0.size() >= 5) begin
      chk("cyc_1", cq0[0], 1);
      chk("cyc_2", cq0[1], 2);
      chk("cyc_3", cq0[2], 3);
      chk("cyc_wrap", cq0[3], 0);
      chk("cyc_5", cq0[4], 1);
    end
`endif

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
